// File: rtl/spi_frame_ctrl.sv
// Decodes SPI command words into pixel writes for the back bank of a double-buffered
// LED RAM; bank swaps are deferred to the scan driver's frame boundary.
module spi_frame_ctrl #(
    parameter int unsigned NUM_PIXELS  = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter logic [7:0]  BRIGHT_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid,
    input  logic [20:0]       word_data,
    input  logic              frame_done,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [17:0]       wr_data,
    output logic              disp_bank,
    output logic [7:0]        brightness,
    output logic              commit_pending,
    output logic [7:0]        err_count,
    output logic [7:0]        drop_count
);

    localparam logic [2:0] OpNop     = 3'd0;
    localparam logic [2:0] OpSetAddr = 3'd1;
    localparam logic [2:0] OpWrite   = 3'd2;
    localparam logic [2:0] OpCommit  = 3'd3;
    localparam logic [2:0] OpBright  = 3'd4;

    typedef enum logic {StIdle, StWrite} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [17:0]         wr_data_q, wr_data_d;
    logic                disp_bank_q, disp_bank_d;
    logic [7:0]          bright_q, bright_d;
    logic                pending_q, pending_d;
    logic [7:0]          err_q, err_d;
    logic [7:0]          drop_q, drop_d;

    logic [2:0]          op;
    logic [17:0]         payload;
    logic [ADDR_W-1:0]   ptr_next;

    assign op       = word_data[20:18];
    assign payload  = word_data[17:0];
    assign ptr_next = (32'(ptr_q) == NUM_PIXELS - 1) ? '0 : ptr_q + ADDR_W'(1);

    always_comb begin
        state_d     = StIdle;
        ptr_d       = ptr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        disp_bank_d = disp_bank_q;
        bright_d    = bright_q;
        pending_d   = pending_q;
        err_d       = err_q;
        drop_d      = drop_q;

        // Swap uses the pending flag from before this edge, so a COMMIT arriving
        // alongside frame_done waits for the next frame.
        if (frame_done && pending_q) begin
            disp_bank_d = ~disp_bank_q;
            pending_d   = 1'b0;
            ptr_d       = '0;
        end

        if (word_valid) begin
            case (op)
                OpNop: ;
                OpSetAddr: begin
                    if (!pending_q) begin
                        if (32'(payload) >= NUM_PIXELS) begin
                            ptr_d = '0;
                            if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        end else begin
                            ptr_d = payload[ADDR_W-1:0];
                        end
                    end
                end
                OpWrite: begin
                    if (pending_q) begin
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        state_d   = StWrite;
                        wr_addr_d = ptr_q;
                        wr_data_d = payload;
                        ptr_d     = ptr_next;
                    end
                end
                OpCommit: begin
                    if (!pending_q) pending_d = 1'b1;
                end
                OpBright: bright_d = payload[7:0];
                default: begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            disp_bank_q <= 1'b0;
            bright_q    <= BRIGHT_INIT;
            pending_q   <= 1'b0;
            err_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            disp_bank_q <= disp_bank_d;
            bright_q    <= bright_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign wr_en          = (state_q == StWrite);
    assign wr_bank        = ~disp_bank_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign disp_bank      = disp_bank_q;
    assign brightness     = bright_q;
    assign commit_pending = pending_q;
    assign err_count      = err_q;
    assign drop_count     = drop_q;

endmodule
